user_wb_slave: RTL and testbench

- Wishbone-classic register slave in the Caravel user area (user_project_wrapper); firmware loaded from SPI flash reaches it on the management Wishbone bus.
- Provides an ID register, control, GPIO output/input, scratch and cycle-counter registers.
- CTRL.done drives mprj_io[10], the flag the system bench waits on to declare pass.

---
 rtl/user_wb_pkg.sv | 22 ++
 rtl/user_wb_if.sv | 23 ++
 rtl/wb_byte_reg.sv | 21 ++
 rtl/user_wb_slave.sv | 105 ++++++++++
 tb/tb_user_wb_slave.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/user_wb_pkg.sv
// Shared constants for the user-area Wishbone register slave.
// Register offsets are byte offsets within the 256-byte window.
package user_wb_pkg;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h3000_0000;
    localparam logic [31:0] DEF_ID_VALUE  = 32'h5052_4553;

    localparam logic [7:0] REG_ID       = 8'h00;
    localparam logic [7:0] REG_CTRL     = 8'h04;
    localparam logic [7:0] REG_OUT      = 8'h08;
    localparam logic [7:0] REG_IN       = 8'h0C;
    localparam logic [7:0] REG_SCRATCH0 = 8'h10;
    localparam logic [7:0] REG_SCRATCH1 = 8'h14;
    localparam logic [7:0] REG_SCRATCH2 = 8'h18;
    localparam logic [7:0] REG_SCRATCH3 = 8'h1C;
    localparam logic [7:0] REG_CNT      = 8'h20;

    localparam int CTRL_DONE_BIT = 0;

    localparam int NUM_SCRATCH = 4;

endpackage

// File: rtl/user_wb_if.sv
// Wishbone-classic slave port bundle as seen from the management SoC.
interface user_wb_if;

    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/wb_byte_reg.sv
// 32-bit register with per-byte write enables; synchronous reset to zero.
module wb_byte_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [3:0]  sel,
    input  logic [31:0] d,
    output logic [31:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (sel[b]) q[b*8 +: 8] <= d[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/user_wb_slave.sv
// Wishbone-classic register slave: ID, CTRL, OUT, IN, SCRATCH0..3, CNT.
// One-cycle registered ack; CTRL.done drives mprj_io[10].
module user_wb_slave
    import user_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter logic [31:0] ID_VALUE  = DEF_ID_VALUE
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    user_wb_if.slave      wbs,
    input  logic [37:0]   io_in,
    output logic [37:0]   io_out,
    output logic [37:0]   io_oeb
);

    logic        hit;
    logic        xfer;
    logic        wr;
    logic [7:0]  offset;
    logic        scratch_hit;
    logic [1:0]  scratch_idx;
    logic [31:0] rdata;
    logic        ctrl_done;
    logic [31:0] cnt;
    logic [31:0] out_q;
    logic [31:0] scratch_q [NUM_SCRATCH];
    logic        unused_bits;

    assign hit    = wbs.wbs_cyc_i && wbs.wbs_stb_i &&
                    (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    // Only accept when ack is low so every transfer gets a single-cycle ack.
    assign xfer   = hit && !wbs.wbs_ack_o;
    assign wr     = xfer && wbs.wbs_we_i;
    assign offset = {wbs.wbs_adr_i[7:2], 2'b00};

    assign scratch_hit = (offset[7:4] == REG_SCRATCH0[7:4]);
    assign scratch_idx = offset[3:2];

    wb_byte_reg u_out_reg (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .we  (wr && (offset == REG_OUT)),
        .sel (wbs.wbs_sel_i),
        .d   (wbs.wbs_dat_i),
        .q   (out_q)
    );

    for (genvar i = 0; i < NUM_SCRATCH; i++) begin : g_scratch
        wb_byte_reg u_scratch_reg (
            .clk (wb_clk_i),
            .rst (wb_rst_i),
            .we  (wr && scratch_hit && (scratch_idx == 2'(i))),
            .sel (wbs.wbs_sel_i),
            .d   (wbs.wbs_dat_i),
            .q   (scratch_q[i])
        );
    end

    always_comb begin
        rdata = '0;
        if (scratch_hit) begin
            rdata = scratch_q[scratch_idx];
        end else begin
            case (offset)
                REG_ID:   rdata = ID_VALUE;
                REG_CTRL: rdata = {31'b0, ctrl_done};
                REG_OUT:  rdata = out_q;
                REG_IN:   rdata = io_in[31:0];
                REG_CNT:  rdata = cnt;
                default:  rdata = '0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ctrl_done <= 1'b0;
        end else if (wr && (offset == REG_CTRL) && wbs.wbs_sel_i[0]) begin
            ctrl_done <= wbs.wbs_dat_i[CTRL_DONE_BIT];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) cnt <= '0;
        else          cnt <= cnt + 32'd1;
    end

    // Read data only updates with a fresh ack and otherwise holds.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs.wbs_ack_o <= 1'b0;
            wbs.wbs_dat_o <= '0;
        end else begin
            wbs.wbs_ack_o <= xfer;
            if (xfer) wbs.wbs_dat_o <= rdata;
        end
    end

    assign io_out = {out_q[26:0], ctrl_done, 10'b0};
    assign io_oeb = {28'b0, 10'h3FF};

    assign unused_bits = ^{wbs.wbs_adr_i[1:0], io_in[37:32], out_q[31:27]};

endmodule

// File: tb/tb_user_wb_slave.sv
// Directed plus randomized bus traffic against a register-map model of the slave.
module tb_user_wb_slave;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] IDV  = 32'h5052_4553;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [37:0] io_in = '0;
    logic [37:0] io_out;
    logic [37:0] io_oeb;

    user_wb_if bus ();

    user_wb_slave dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs      (bus),
        .io_in    (io_in),
        .io_out   (io_out),
        .io_oeb   (io_oeb)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int edge_no = 0;
    int last_rst_edge = 0;
    int ack_edge = 0;

    always @(posedge clk) begin
        edge_no++;
        if (rst) last_rst_edge = edge_no;
    end

    // Architectural model of the register file.
    logic [31:0] m_out;
    logic        m_done;
    logic [31:0] m_scr [4];

    task automatic model_reset();
        m_out  = '0;
        m_done = 1'b0;
        for (int i = 0; i < 4; i++) m_scr[i] = '0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] sel,
                                          input logic [31:0] d);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    task automatic model_write(input int word, input logic [3:0] sel, input logic [31:0] d);
        if (word == 1 && sel[0]) m_done = d[0];
        else if (word == 2) m_out = merge(m_out, sel, d);
        else if (word >= 4 && word <= 7) m_scr[word-4] = merge(m_scr[word-4], sel, d);
    endtask

    function automatic logic [31:0] model_read(input int word, input int e);
        case (word)
            0: return IDV;
            1: return {31'b0, m_done};
            2: return m_out;
            3: return io_in[31:0];
            4, 5, 6, 7: return m_scr[word-4];
            8: return 32'(e - last_rst_edge - 1);
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = '0;
        bus.wbs_dat_i = '0;
    endtask

    // One transfer; lat = edges until ack, or -1 if no ack within 16 edges.
    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                           input logic [31:0] d, output logic [31:0] rd, output int lat);
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_sel_i = sel;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = d;
        lat = -1;
        rd  = '0;
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk);
            #1;
            if (bus.wbs_ack_o) begin
                lat = n;
                break;
            end
        end
        rd = bus.wbs_dat_o;
        ack_edge = edge_no;
        bus_idle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] d);
        logic [31:0] rd;
        int lat;
        wb_xfer(adr, 1'b1, sel, d, rd, lat);
        check("wr_lat", 64'(lat), 64'd1);
        model_write(int'(adr[7:2]), sel, d);
    endtask

    task automatic do_read(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] rd;
        int lat;
        wb_xfer(adr, 1'b0, 4'hF, 32'h0, rd, lat);
        check({tag, "_lat"}, 64'(lat), 64'd1);
        check(tag, 64'(rd), 64'(exp));
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] first;
        logic [31:0] exp;
        logic [37:0] exp_out;
        int lat;
        int word;
        logic we;
        logic [3:0] sel;
        logic [31:0] d;

        bus_idle();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 64'(bus.wbs_ack_o), 64'd0);
        check("rst_dat", 64'(bus.wbs_dat_o), 64'd0);
        check("rst_io_out", 64'(io_out), 64'd0);
        check("rst_io_oeb", 64'(io_oeb), 64'h3FF);
        @(negedge clk);
        rst = 1'b0;

        do_read("rd_id", BASE, IDV);
        do_read("rd_ctrl0", BASE + 32'h04, 32'h0);
        do_read("rd_out0", BASE + 32'h08, 32'h0);
        do_read("rd_scr0", BASE + 32'h10, 32'h0);

        do_write(BASE + 32'h10, 4'hF, 32'hDEAD_BEEF);
        do_write(BASE + 32'h10, 4'b0101, 32'h1234_5678);
        do_read("rd_scr_bytes", BASE + 32'h10, 32'hDE34_BE78);

        do_write(BASE + 32'h04, 4'hF, 32'h1);
        check("done_hi", 64'(io_out[10]), 64'd1);
        check("done_oeb", 64'(io_oeb[10]), 64'd0);
        do_read("rd_ctrl1", BASE + 32'h04, 32'h1);
        do_write(BASE + 32'h04, 4'hF, 32'h0);
        check("done_lo", 64'(io_out[10]), 64'd0);

        do_write(BASE + 32'h08, 4'hF, 32'h07FF_FFFF);
        check("out_hi", 64'(io_out[37:11]), 64'h7FF_FFFF);
        check("out_lo", 64'(io_out[9:0]), 64'd0);
        io_in = 38'h2A_5A5A_A5A5;
        do_read("rd_in", BASE + 32'h0C, 32'h5A5A_A5A5);

        do_write(BASE + 32'h00, 4'hF, 32'hFFFF_FFFF);
        do_read("rd_id_ro", BASE, IDV);
        do_read("rd_unmapped", BASE + 32'h40, 32'h0);

        wb_xfer(32'h3100_0000, 1'b0, 4'hF, 32'h0, rd, lat);
        check("miss_noack", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        bus.wbs_stb_i = 1'b1;
        bus.wbs_adr_i = BASE;
        repeat (4) @(posedge clk);
        #1;
        check("nocyc_noack", 64'(bus.wbs_ack_o), 64'd0);
        bus_idle();

        // Back-to-back CNT reads with strobe held.
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_sel_i = 4'hF;
        bus.wbs_adr_i = BASE + 32'h20;
        @(posedge clk);
        #1;
        check("cnt_ack1", 64'(bus.wbs_ack_o), 64'd1);
        first = bus.wbs_dat_o;
        check("cnt_abs", 64'(first), 64'(model_read(8, edge_no)));
        @(posedge clk);
        #1;
        check("cnt_gap", 64'(bus.wbs_ack_o), 64'd0);
        @(posedge clk);
        #1;
        check("cnt_ack2", 64'(bus.wbs_ack_o), 64'd1);
        check("cnt_plus2", 64'(bus.wbs_dat_o), 64'(first + 32'd2));
        bus_idle();
        @(posedge clk);
        #1;

        // Reset landing on a write: nothing is acked and nothing is written.
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b1;
        bus.wbs_sel_i = 4'hF;
        bus.wbs_adr_i = BASE + 32'h14;
        bus.wbs_dat_i = 32'hAAAA_5555;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_ack", 64'(bus.wbs_ack_o), 64'd0);
        bus_idle();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        do_read("rst_mid_scr", BASE + 32'h14, 32'h0);
        do_read("rst_mid_scr0", BASE + 32'h10, 32'h0);

        for (int k = 0; k < 60; k++) begin
            word = int'($urandom_range(0, 15));
            we   = 1'($urandom);
            sel  = 4'($urandom);
            d    = $urandom;
            io_in = 38'({$urandom, $urandom});
            wb_xfer(BASE + 32'(word * 4), we, sel, d, rd, lat);
            check("rnd_lat", 64'(lat), 64'd1);
            if (we) begin
                model_write(word, sel, d);
            end else begin
                exp = model_read(word, ack_edge);
                check($sformatf("rnd_rd_w%0d", word), 64'(rd), 64'(exp));
            end
            exp_out = {m_out[26:0], m_done, 10'b0};
            check("rnd_io_out", 64'(io_out), 64'(exp_out));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
